t_flipflop_bank: RTL and testbench

//  WIDTH-bit register bank built on toggle flip-flop semantics; the parametrised

---
 rtl/t_flipflop_bank.sv | 90 +++++++++
 tb/tb_t_flipflop_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/t_flipflop_bank.sv
// WIDTH-bit toggle/count register bank with parallel load and a registered terminal-count pulse.
// Define TFF_BANK_SAT_EN to make counting saturate at the limits instead of wrapping.
module t_flipflop_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_C = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1'b1);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;

  // Next-state selection: load beats enabled mode operations, which beat hold.
  always_comb begin
    q_nxt_s  = q_r;
    tc_nxt_s = 1'b0;
    if (load) begin
      q_nxt_s = din;
    end else if (en) begin
      case (mode)
        2'b00: begin
          q_nxt_s = q_r;
        end
        2'b01: begin
          q_nxt_s = q_r ^ t;
        end
        2'b10: begin
          if (q_r == ONES_C) begin
            tc_nxt_s = 1'b1;
`ifdef TFF_BANK_SAT_EN
            q_nxt_s  = q_r;
`else
            q_nxt_s  = ZERO_C;
`endif
          end else begin
            q_nxt_s = q_r + ONE_C;
          end
        end
        2'b11: begin
          if (q_r == ZERO_C) begin
            tc_nxt_s = 1'b1;
`ifdef TFF_BANK_SAT_EN
            q_nxt_s  = q_r;
`else
            q_nxt_s  = ONES_C;
`endif
          end else begin
            q_nxt_s = q_r - ONE_C;
          end
        end
        default: begin
          q_nxt_s = q_r;
        end
      endcase
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State and terminal-count registers; reset overrides any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r  <= RESET_VAL;
      tc_r <= 1'b0;
    end else begin
      q_r  <= q_nxt_s;
      tc_r <= tc_nxt_s;
    end
  end

  assign q     = q_r;
  assign q_bar = ~q_r;
  assign tc    = tc_r;

endmodule

// File: tb/tb_t_flipflop_bank.sv
// Scoreboard bench for t_flipflop_bank (WIDTH=4 main instance, WIDTH=1/RESET_VAL=1 sweep instance).
// Expected values follow the wrap or saturating behaviour depending on TFF_BANK_SAT_EN.
module tb_t_flipflop_bank;

`ifdef TFF_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] t;
  logic       load;
  logic [3:0] din;
  logic [3:0] q;
  logic [3:0] q_bar;
  logic       tc;

  logic       en1;
  logic [1:0] mode1;
  logic [0:0] t1;
  logic       load1;
  logic [0:0] din1;
  logic [0:0] q1;
  logic [0:0] q1_bar;
  logic       tc1;

  int   n_total;
  int   n_bad;
  exp_t sb[$];
  logic [3:0] m_q;
  logic       m_tc;

  t_flipflop_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .t(t),
    .load(load), .din(din), .q(q), .q_bar(q_bar), .tc(tc)
  );

  t_flipflop_bank #(.WIDTH(1), .RESET_VAL(1'b1)) dut_w1 (
    .clk(clk), .reset(reset), .en(en1), .mode(mode1), .t(t1),
    .load(load1), .din(din1), .q(q1), .q_bar(q1_bar), .tc(tc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, applied to the bench's own state copy.
  task automatic model_edge(input logic l, input logic [3:0] d, input logic e,
                            input logic [1:0] m, input logic [3:0] tt);
    m_tc = 1'b0;
    if (l) begin
      m_q = d;
    end else if (e) begin
      case (m)
        2'b01: m_q = m_q ^ tt;
        2'b10: begin
          if (m_q == 4'hF) begin
            m_tc = 1'b1;
            if (!SAT) m_q = 4'h0;
          end else m_q = 4'((int'(m_q) + 1) % 16);
        end
        2'b11: begin
          if (m_q == 4'h0) begin
            m_tc = 1'b1;
            if (!SAT) m_q = 4'hF;
          end else m_q = 4'((int'(m_q) + 15) % 16);
        end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic l, input logic [3:0] d, input logic e,
                      input logic [1:0] m, input logic [3:0] tt);
    exp_t x;
    load = l; din = d; en = e; mode = m; t = tt;
    model_edge(l, d, e, m, tt);
    sb.push_back('{q: m_q, tc: m_tc});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check_val({tag, "_q"}, {28'd0, q}, {28'd0, x.q});
      check_val({tag, "_qbar"}, {28'd0, q_bar}, {28'd0, ~x.q});
      check_val({tag, "_tc"}, {31'd0, tc}, {31'd0, x.tc});
    end
  endtask

  task automatic do_reset_check(input string tag);
    reset = 1'b0;
    m_q = 4'h0;
    m_tc = 1'b0;
    #1;
    check_val({tag, "_q"}, {28'd0, q}, 32'h0);
    check_val({tag, "_qbar"}, {28'd0, q_bar}, 32'hF);
    check_val({tag, "_tc"}, {31'd0, tc}, 32'h0);
    check_val({tag, "_q1"}, {31'd0, q1}, 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] e1_q;
    logic [2:0] e1_tc;
    n_total = 0;
    n_bad = 0;
    reset = 1'b0;
    en = 1'b0; mode = 2'b00; t = 4'h0; load = 1'b0; din = 4'h0;
    en1 = 1'b0; mode1 = 2'b00; t1 = 1'b0; load1 = 1'b0; din1 = 1'b0;
    m_q = 4'h0; m_tc = 1'b0;
    @(posedge clk); #2;
    do_reset_check("por");
    @(negedge clk);
    reset = 1'b1;

    // async reset between edges, then release with counting already requested
    step("ld_a", 1'b1, 4'hA, 1'b0, 2'b00, 4'h0);
    #2;
    do_reset_check("rst_mid");
    en = 1'b1; mode = 2'b10; load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("rel_noedge_q", {28'd0, q}, 32'h0);
    step("rel_first", 1'b0, 4'h0, 1'b1, 2'b10, 4'h0);

    // toggle mask
    step("ld_5", 1'b1, 4'h5, 1'b0, 2'b00, 4'h0);
    step("tog1", 1'b0, 4'h0, 1'b1, 2'b01, 4'h3);
    step("tog2", 1'b0, 4'h0, 1'b1, 2'b01, 4'h3);
    step("tog0", 1'b0, 4'h0, 1'b1, 2'b01, 4'h0);

    // count up across the limit, reset while tc is high
    step("ld_e", 1'b1, 4'hE, 1'b0, 2'b00, 4'h0);
    step("up1", 1'b0, 4'h0, 1'b1, 2'b10, 4'h0);
    step("up2", 1'b0, 4'h0, 1'b1, 2'b10, 4'h0);
    step("up3", 1'b0, 4'h0, 1'b1, 2'b10, 4'h0);
    #2;
    do_reset_check("rst_cnt");
    #2;
    reset = 1'b1;

    // count down across zero
    step("ld_1", 1'b1, 4'h1, 1'b0, 2'b00, 4'h0);
    step("dn1", 1'b0, 4'h0, 1'b1, 2'b11, 4'h0);
    step("dn2", 1'b0, 4'h0, 1'b1, 2'b11, 4'h0);
    step("dn3", 1'b0, 4'h0, 1'b1, 2'b11, 4'h0);

    // priority: load over counting, en=0 holds, mode 00 holds
    step("ld_f", 1'b1, 4'hF, 1'b0, 2'b00, 4'h0);
    step("prio_ld", 1'b1, 4'h7, 1'b1, 2'b10, 4'h0);
    step("en0_hold", 1'b0, 4'h0, 1'b0, 2'b10, 4'hF);
    step("m00_hold", 1'b0, 4'h0, 1'b1, 2'b00, 4'hF);

    // WIDTH=1, RESET_VAL=1 continuous count
    if (SAT) begin
      e1_q = 3'b111; e1_tc = 3'b111;
    end else begin
      e1_q = 3'b010; e1_tc = 3'b101;
    end
    en1 = 1'b1; mode1 = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step("w1_main", 1'b0, 4'h0, 1'b0, 2'b00, 4'h0);
      check_val($sformatf("w1_q_%0d", i), {31'd0, q1}, {31'd0, e1_q[i]});
      check_val($sformatf("w1_tc_%0d", i), {31'd0, tc1}, {31'd0, e1_tc[i]});
    end
    en1 = 1'b0; mode1 = 2'b00;

    // random mix
    for (int i = 0; i < 60; i++) begin
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    check_val("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
